// File: rtl/cpu_pipe_pkg.sv
// Shared types for the ID->EX->MEM->WB pipeline control logic.
//   REG_ADDR_W  : GPR address width (32 registers)
//   shadow_t    : per-stage destination bookkeeping {valid, rd, we, is_load}
//   fwd_sel_t   : one-hot ALU operand bypass select {alu_alu, bypass_alu, dmem_alu}
//   is_writer() : stage will actually update a non-r0 register
package cpu_pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      we;
        logic      is_load;
    } shadow_t;

    typedef struct packed {
        logic alu_alu;     // alu_out_d2 (producer one stage ahead)
        logic bypass_alu;  // alu_out_d3 (ALU producer two stages ahead)
        logic dmem_alu;    // DOut_d3    (load producer two stages ahead)
    } fwd_sel_t;

    localparam fwd_sel_t FwdNone    = 3'b000;
    localparam fwd_sel_t FwdExAlu   = 3'b100;
    localparam fwd_sel_t FwdMemAlu  = 3'b010;
    localparam fwd_sel_t FwdMemDmem = 3'b001;

    // r0 is hardwired to zero, so a write to it never produces a value worth bypassing.
    function automatic logic is_writer(input shadow_t s);
        return s.valid & s.we & (s.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Per-operand bypass source selection (purely combinational).
//   use_rs  in  : consumer actually reads this operand
//   rs      in  : consumer source register
//   ex_sh   in  : shadow of the instruction currently in EX
//   mem_sh  in  : shadow of the instruction currently in MEM
//   sel     out : one-hot select, nearest producer wins, FwdNone when no hazard
module fwd_src_sel
    import cpu_pipe_pkg::*;
(
    input  logic      use_rs,
    input  reg_addr_t rs,
    input  shadow_t   ex_sh,
    input  shadow_t   mem_sh,
    output fwd_sel_t  sel
);

    always_comb begin
        sel = FwdNone;
        if (use_rs && (rs != '0)) begin
            // A load in EX has no data yet; the stall logic covers that case, so fall through
            // to the older MEM producer here.
            if (is_writer(ex_sh) && (ex_sh.rd == rs) && !ex_sh.is_load) begin
                sel = FwdExAlu;
            end else if (is_writer(mem_sh) && (mem_sh.rd == rs)) begin
                sel = mem_sh.is_load ? FwdMemDmem : FwdMemAlu;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the ALU operand bypass muxes.
//   clk, rst_n              : clock, asynchronous active-low reset
//   pipe_adv                : pipeline advance; 0 freezes all state here
//   flush                   : kill the instruction entering EX
//   id_*                    : decoded ID-stage instruction (sources, dest, load flag)
//   alu_alu_s1/2            : operand <= alu_out_d2
//   bypass_alu1/2           : operand <= alu_out_d3
//   dmem_alu1/2             : operand <= DOut_d3
//   stall_id                : combinational load-use stall (hold IF/ID, bubble into EX)
//   stall_count             : saturating count of advancing stall cycles
module fwd_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_adv,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_we,
    input  logic                  id_is_load,
    output logic                  alu_alu_s1,
    output logic                  bypass_alu1,
    output logic                  dmem_alu1,
    output logic                  alu_alu_s2,
    output logic                  bypass_alu2,
    output logic                  dmem_alu2,
    output logic                  stall_id,
    output logic [CNT_W-1:0]      stall_count
);

    // The WB slot is not tracked: a producer three stages ahead has already been written
    // through the register file, so nothing here ever reads it.
    shadow_t        ex_q, ex_d, mem_q;
    fwd_sel_t       sel1_d, sel1_q, sel2_d, sel2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           ex_load_hit;
    logic           bubble;

    fwd_src_sel u_sel_op1 (
        .use_rs (id_use_rs1),
        .rs     (id_rs1),
        .ex_sh  (ex_q),
        .mem_sh (mem_q),
        .sel    (sel1_d)
    );

    fwd_src_sel u_sel_op2 (
        .use_rs (id_use_rs2),
        .rs     (id_rs2),
        .ex_sh  (ex_q),
        .mem_sh (mem_q),
        .sel    (sel2_d)
    );

    always_comb begin
        ex_load_hit = is_writer(ex_q) & ex_q.is_load &
                      ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
        // flush outranks the stall: the consumer is being killed anyway.
        stall_id    = id_valid & ~flush & ex_load_hit;
        bubble      = stall_id | flush | ~id_valid;

        ex_d         = '0;
        ex_d.valid   = ~bubble;
        ex_d.rd      = bubble ? '0 : id_rd;
        ex_d.we      = ~bubble & id_reg_we;
        ex_d.is_load = ~bubble & id_is_load;

        cnt_d = cnt_q;
        if (stall_id && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= '0;
            mem_q  <= '0;
            sel1_q <= FwdNone;
            sel2_q <= FwdNone;
            cnt_q  <= '0;
        end else if (pipe_adv) begin
            mem_q  <= ex_q;
            ex_q   <= ex_d;
            sel1_q <= bubble ? FwdNone : sel1_d;
            sel2_q <= bubble ? FwdNone : sel2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign alu_alu_s1  = sel1_q.alu_alu;
    assign bypass_alu1 = sel1_q.bypass_alu;
    assign dmem_alu1   = sel1_q.dmem_alu;
    assign alu_alu_s2  = sel2_q.alu_alu;
    assign bypass_alu2 = sel2_q.bypass_alu;
    assign dmem_alu2   = sel2_q.dmem_alu;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl; a small stage model predicts stall and selects.
module tb_fwd_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned CMAX = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic pipe_adv, flush, id_valid, id_use_rs1, id_use_rs2, id_reg_we, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic alu_alu_s1, bypass_alu1, dmem_alu1, alu_alu_s2, bypass_alu2, dmem_alu2, stall_id;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic       m_ex_v, m_ex_we, m_ex_ld, m_mem_v, m_mem_we, m_mem_ld;
    logic [4:0] m_ex_rd, m_mem_rd;
    logic [5:0] m_sel;
    int         m_cnt;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_adv    (pipe_adv),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_reg_we   (id_reg_we),
        .id_is_load  (id_is_load),
        .alu_alu_s1  (alu_alu_s1),
        .bypass_alu1 (bypass_alu1),
        .dmem_alu1   (dmem_alu1),
        .alu_alu_s2  (alu_alu_s2),
        .bypass_alu2 (bypass_alu2),
        .dmem_alu2   (dmem_alu2),
        .stall_id    (stall_id),
        .stall_count (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] dut_sels();
        return {alu_alu_s1, bypass_alu1, dmem_alu1, alu_alu_s2, bypass_alu2, dmem_alu2};
    endfunction

    // Expected one-hot {ex_alu, mem_alu, mem_dmem} for one operand.
    function automatic logic [2:0] exp_sel(input logic [4:0] rs, input logic u);
        if (!u || rs == 5'd0) return 3'b000;
        if (m_ex_v && m_ex_we && m_ex_rd == rs && !m_ex_ld) return 3'b100;
        if (m_mem_v && m_mem_we && m_mem_rd == rs) return m_mem_ld ? 3'b001 : 3'b010;
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_ex_v = 0; m_ex_we = 0; m_ex_ld = 0; m_ex_rd = 0;
        m_mem_v = 0; m_mem_we = 0; m_mem_ld = 0; m_mem_rd = 0;
        m_sel = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    // One clock: drive ID, check stall mid-cycle, push expected selects, check after the edge.
    task automatic cycle(input logic adv, input logic fl, input logic vld,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic we, input logic ld,
                         input string tag, output logic stalled);
        logic exp_stall, bub;
        logic [5:0] nxt;
        pipe_adv = adv; flush = fl; id_valid = vld;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_reg_we = we; id_is_load = ld;
        #2;
        exp_stall = vld && !fl && m_ex_v && m_ex_we && m_ex_rd != 0 && m_ex_ld &&
                    ((u1 && rs1 == m_ex_rd) || (u2 && rs2 == m_ex_rd));
        check({tag, ".stall"}, {31'd0, stall_id}, {31'd0, exp_stall});
        stalled = exp_stall;
        bub = exp_stall || fl || !vld;
        nxt = adv ? (bub ? 6'd0 : {exp_sel(rs1, u1), exp_sel(rs2, u2)}) : m_sel;
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        if (adv) begin
            m_mem_v = m_ex_v; m_mem_we = m_ex_we; m_mem_ld = m_ex_ld; m_mem_rd = m_ex_rd;
            m_ex_v = !bub; m_ex_we = !bub && we; m_ex_ld = !bub && ld; m_ex_rd = bub ? 5'd0 : rd;
            m_sel = nxt;
            if (exp_stall && m_cnt < CMAX) m_cnt++;
        end
        if (exp_q.size() == 0) check({tag, ".sel_queue"}, 32'd0, 32'd1);
        else check({tag, ".sel"}, {26'd0, dut_sels()}, {26'd0, exp_q.pop_front()});
        check({tag, ".cnt"}, {28'd0, stall_count}, m_cnt);
    endtask

    // ALU op rd <- rs1, rs2; re-issued while the ID stage is stalled.
    task automatic op_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input string tag);
        logic st;
        int n = 0;
        do begin
            cycle(1, 0, 1, rs1, 1, rs2, 1, rd, 1, 0, tag, st);
            n++;
        end while (st && n < 4);
        if (st) check({tag, ".stall_bound"}, 32'd1, 32'd0);
    endtask

    task automatic op_ld(input logic [4:0] rd, input logic [4:0] rs1, input string tag);
        logic st;
        cycle(1, 0, 1, rs1, 1, 5'd0, 0, rd, 1, 1, tag, st);
    endtask

    task automatic nop(input string tag);
        logic st;
        cycle(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, tag, st);
    endtask

    initial begin
        logic st;
        rst_n = 0;
        pipe_adv = 0; flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0; id_reg_we = 0; id_is_load = 0;
        model_reset();
        #3;
        check("reset.sel", {26'd0, dut_sels()}, 32'd0);
        check("reset.stall", {31'd0, stall_id}, 32'd0);
        check("reset.cnt", {28'd0, stall_count}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // 1: back-to-back ALU dependency on both operands
        op_r(5'd3, 5'd1, 5'd2, "t1.add");
        op_r(5'd4, 5'd3, 5'd3, "t1.sub");
        check("t1.exex", {26'd0, dut_sels()}, 32'b100100);

        // 2: distance-2 on op2 only, then distance-3 gets nothing
        op_r(5'd5, 5'd1, 5'd2, "t2.add");
        nop("t2.nop");
        op_r(5'd6, 5'd1, 5'd5, "t2.or");
        check("t2.memalu", {26'd0, dut_sels()}, 32'b000010);
        op_r(5'd9, 5'd1, 5'd2, "t2.p3");
        nop("t2.nop2");
        nop("t2.nop3");
        op_r(5'd10, 5'd9, 5'd9, "t2.c3");
        check("t2.dist3", {26'd0, dut_sels()}, 32'd0);

        // 3: load-use: one stall, then DOut bypass
        op_ld(5'd7, 5'd1, "t3.lw");
        op_r(5'd8, 5'd7, 5'd2, "t3.add");
        check("t3.dmem", {26'd0, dut_sels()}, 32'b001000);
        check("t3.cnt", {28'd0, stall_count}, 32'd1);

        // 4: r0 is never forwarded and never stalls
        op_r(5'd0, 5'd1, 5'd2, "t4.w0");
        op_r(5'd11, 5'd0, 5'd0, "t4.r0");
        check("t4.r0sel", {26'd0, dut_sels()}, 32'd0);
        op_ld(5'd0, 5'd1, "t4.lw0");
        op_r(5'd12, 5'd0, 5'd0, "t4.r0ld");

        // 5: flush beats the load-use stall, then a frozen pipe holds everything
        op_ld(5'd7, 5'd1, "t5.lw");
        cycle(1, 1, 1, 5'd7, 1, 5'd2, 1, 5'd8, 1, 0, "t5.flush", st);
        check("t5.flush_sel", {26'd0, dut_sels()}, 32'd0);
        op_r(5'd13, 5'd1, 5'd2, "t5.pre");
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 5'd13, 1, 5'd7, 1, 5'd14, 1, 0, "t5.hold", st);
        end
        op_r(5'd14, 5'd13, 5'd7, "t5.go");
        // freeze while a load-use stall is asserted: stall visible, count unchanged
        op_ld(5'd7, 5'd1, "t5.lw2");
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 1, 5'd7, 1, 5'd2, 1, 5'd8, 1, 0, "t5.frz", st);
        end
        op_r(5'd8, 5'd7, 5'd2, "t5.use");

        // 6: saturate the counter, then reset mid-stall
        for (int i = 0; i < 16; i++) begin
            op_ld(5'd7, 5'd1, "t6.lw");
            op_r(5'd8, 5'd7, 5'd2, "t6.use");
        end
        check("t6.sat", {28'd0, stall_count}, CMAX);
        op_ld(5'd7, 5'd1, "t6.lw_rst");
        pipe_adv = 1; flush = 0; id_valid = 1; id_rs1 = 5'd7; id_use_rs1 = 1;
        id_rs2 = 5'd7; id_use_rs2 = 1; id_rd = 5'd8; id_reg_we = 1; id_is_load = 0;
        #2;
        check("t6.pre_stall", {31'd0, stall_id}, 32'd1);
        rst_n = 0;
        #1;
        check("t6.rst_stall", {31'd0, stall_id}, 32'd0);
        check("t6.rst_sel", {26'd0, dut_sels()}, 32'd0);
        check("t6.rst_cnt", {28'd0, stall_count}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        op_ld(5'd7, 5'd1, "t6.post_lw");
        op_r(5'd8, 5'd7, 5'd7, "t6.post_use");
        check("t6.post_dmem", {26'd0, dut_sels()}, 32'b001001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
